// File: rtl/grid_arb_pkg.sv
// -----------------------------------------------------------------------------
// grid_arb_pkg
//   Shared defaults and encodings for the grid-RAM write arbiter:
//   - default grid geometry (address width, colour width, cell count)
//   - arbiter FSM state enum
//   - requester id encoding (0 = processor paint, 1 = wall painter)
// -----------------------------------------------------------------------------
package grid_arb_pkg;

    localparam int unsigned GRID_ADDR_W    = 12;
    localparam int unsigned GRID_DATA_W    = 4;
    localparam int unsigned GRID_CELLS_DEF = 4096;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_P0 = 1'b0,
        REQ_P1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/grid_clear_seq.sv
// -----------------------------------------------------------------------------
// grid_clear_seq
//   Full-grid clear sequencer. Produces the next clear write (address/colour)
//   one cycle ahead so that the arbiter's registered write port shows cell k
//   while the counter holds k.
//
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   start_i        accepted clear start (arbiter in ARB with clear_start)
//   active_i       arbiter is in CLEAR
//   color_i        fill colour, latched on start_i
//   last_o         counter holds the final cell (sweep ends this cycle)
//   wr_req_o       a clear write must be loaded into the port registers
//   wr_addr_o      address for that write
//   wr_data_o      colour for that write
//   busy_o         registered: high on every cycle a clear write is shown
//   done_o         registered: pulse the cycle after the last clear write
// -----------------------------------------------------------------------------
module grid_clear_seq
    import grid_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = GRID_ADDR_W,
    parameter int unsigned DATA_W     = GRID_DATA_W,
    parameter int unsigned GRID_CELLS = GRID_CELLS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic              active_i,
    input  logic [DATA_W-1:0] color_i,
    output logic              last_o,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    // One extra counter bit keeps the terminal compare exact when
    // GRID_CELLS equals 2**ADDR_W.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(GRID_CELLS - 1);

    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] color_q, color_d;
    logic              busy_q, done_q;

    assign cnt_inc   = cnt_q + (ADDR_W + 1)'(1);
    assign last_o    = active_i && (cnt_q == CNT_LAST);
    assign wr_req_o  = start_i || (active_i && !last_o);
    assign wr_addr_o = start_i ? '0 : cnt_inc[ADDR_W-1:0];
    assign wr_data_o = start_i ? color_i : color_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    always_comb begin
        cnt_d   = cnt_q;
        color_d = color_q;
        if (start_i) begin
            cnt_d   = '0;
            color_d = color_i;
        end else if (active_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            color_q <= color_d;
            busy_q  <= wr_req_o;
            done_q  <= last_o;
        end
    end

endmodule

// File: rtl/grid_write_arbiter.sv
// -----------------------------------------------------------------------------
// grid_write_arbiter
//   Shares the single write port of the VGA grid-data RAM between the
//   processor paint path (p0), the wall painter (p1) and a built-in full-grid
//   clear sequencer. At most one write per cycle; p0/p1 are served
//   round-robin; a clear start takes priority and runs to completion.
//   All outputs are registered; a request sampled in cycle N is written and
//   acked in cycle N+1.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   p0_req/p0_addr/p0_data  processor paint request, held until p0_ack
//   p0_ack                  pulse: p0 write is on the port this cycle
//   p1_req/p1_addr/p1_data  wall paint request, held until p1_ack
//   p1_ack                  pulse: p1 write is on the port this cycle
//   clear_start             pulse: start a full-grid clear (ignored mid-clear)
//   clear_color             fill colour, sampled with an accepted clear_start
//   clear_busy              high while clear writes are on the port
//   clear_done              pulse the cycle after the last clear write
//   wr_en/wr_addr/wr_data   grid RAM write port
//   bounds_err              sticky out-of-range flag
//
// Build option:
//   GRID_ARB_BOUNDS_CHECK_EN  when defined, a granted request with
//                             addr >= GRID_CELLS is acked but not written,
//                             and bounds_err sets until reset. When undefined
//                             bounds_err stays 0 and addresses pass unchecked.
// -----------------------------------------------------------------------------
module grid_write_arbiter
    import grid_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = GRID_ADDR_W,
    parameter int unsigned DATA_W     = GRID_DATA_W,
    parameter int unsigned GRID_CELLS = GRID_CELLS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ack,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              bounds_err
);

    arb_state_e state_q, state_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              bounds_err_q, bounds_err_d;
    req_id_e           last_grant_q, last_grant_d;

    logic              clr_start, clr_active, clr_last, clr_wr_req;
    logic [ADDR_W-1:0] clr_wr_addr;
    logic [DATA_W-1:0] clr_wr_data;

    logic              p0_elig, p1_elig;
    logic              grant_valid;
    req_id_e           grant_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              in_range;

    assign clr_start  = (state_q == ARB) && clear_start;
    assign clr_active = (state_q == CLEAR);

    grid_clear_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .GRID_CELLS (GRID_CELLS)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .start_i   (clr_start),
        .active_i  (clr_active),
        .color_i   (clear_color),
        .last_o    (clr_last),
        .wr_req_o  (clr_wr_req),
        .wr_addr_o (clr_wr_addr),
        .wr_data_o (clr_wr_data),
        .busy_o    (clear_busy),
        .done_o    (clear_done)
    );

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            bounds_err_q <= 1'b0;
            last_grant_q <= REQ_P1;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            bounds_err_q <= bounds_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (clear_start) state_d = CLEAR;
            CLEAR:   if (clr_last)    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // A requester whose ack is showing this cycle is still holding req from
    // the write just completed; excluding it prevents a duplicate write.
    assign p0_elig = p0_req && !p0_ack_q;
    assign p1_elig = p1_req && !p1_ack_q;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_P0;
        if ((state_q == ARB) && !clear_start) begin
            if (p0_elig && p1_elig) begin
                grant_valid = 1'b1;
                grant_id    = (last_grant_q == REQ_P1) ? REQ_P0 : REQ_P1;
            end else if (p0_elig) begin
                grant_valid = 1'b1;
                grant_id    = REQ_P0;
            end else if (p1_elig) begin
                grant_valid = 1'b1;
                grant_id    = REQ_P1;
            end
        end
    end

    assign sel_addr = (grant_id == REQ_P1) ? p1_addr : p0_addr;
    assign sel_data = (grant_id == REQ_P1) ? p1_data : p0_data;

`ifdef GRID_ARB_BOUNDS_CHECK_EN
    assign in_range = (32'(sel_addr) < GRID_CELLS);
`else
    assign in_range = 1'b1;
`endif

    // Output next-values
    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        bounds_err_d = bounds_err_q;
        last_grant_d = last_grant_q;
        if (clr_wr_req) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_wr_addr;
            wr_data_d = clr_wr_data;
        end else if (grant_valid) begin
            p0_ack_d     = (grant_id == REQ_P0);
            p1_ack_d     = (grant_id == REQ_P1);
            last_grant_d = grant_id;
            // Out-of-range requests are still acked so the requester
            // never hangs; only the RAM write is suppressed.
            if (in_range) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
            end else begin
                bounds_err_d = 1'b1;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;
    assign bounds_err = bounds_err_q;

endmodule

// File: tb/tb_grid_write_arbiter.sv
module tb_grid_write_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 4;
    localparam int unsigned GC = 16;
`ifdef GRID_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          p0_req, p1_req, clear_start;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data, clear_color;
    logic          p0_ack, p1_ack, clear_busy, clear_done, wr_en, bounds_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clock = ~clock;

    grid_write_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .GRID_CELLS (GC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .p0_req      (p0_req),
        .p0_addr     (p0_addr),
        .p0_data     (p0_data),
        .p0_ack      (p0_ack),
        .p1_req      (p1_req),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .p1_ack      (p1_ack),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bounds_err  (bounds_err)
    );

    int checks   = 0;
    int failures = 0;

    // Observed output bundle: {en, addr, data, ack0, ack1, busy, done, berr}
    typedef logic [21:0] obs_t;

    function automatic obs_t pk(logic en, logic [AW-1:0] a, logic [DW-1:0] d,
                                logic k0, logic k1, logic busy, logic done, logic be);
        return {en, a, d, k0, k1, busy, done, be};
    endfunction

    function automatic obs_t obs();
        return {wr_en, wr_addr, wr_data, p0_ack, p1_ack, clear_busy, clear_done, bounds_err};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got en=%0d addr=%h data=%h ack0=%0d ack1=%0d busy=%0d done=%0d berr=%0d; expected en=%0d addr=%h data=%h ack0=%0d ack1=%0d busy=%0d done=%0d berr=%0d",
                     name, $time,
                     act[21], act[20:9], act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[21], exp[20:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic cs, input logic [DW-1:0] cc,
                         input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        reset = rst; clear_start = cs; clear_color = cc;
        p0_req = r0; p0_addr = a0; p0_data = d0;
        p1_req = r1; p1_addr = a1; p1_data = d1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string         name;
        logic          rst;
        logic          r0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        obs_t          exp;
    } vec_t;

    vec_t tbl[12];

    // ---------------- reference model ----------------
    // Expected port contents for the cycle after the coming edge.
    bit            m_clearing;
    int            m_idx;
    logic [DW-1:0] m_col;
    int            m_last;
    bit            m_ack [2];
    logic          e_en, e_busy, e_done, e_berr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic model_edge();
        bit            req [2];
        bit            prev_ack [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dt [2];
        int            win;
        req[0] = p0_req; req[1] = p1_req;
        ad[0]  = p0_addr; ad[1] = p1_addr;
        dt[0]  = p0_data; dt[1] = p1_data;
        prev_ack = m_ack;
        win = -1;
        if (reset) begin
            m_clearing = 0; m_idx = 0; m_col = '0; m_last = 1;
            m_ack[0] = 0; m_ack[1] = 0;
            e_en = 0; e_addr = '0; e_data = '0; e_busy = 0; e_done = 0; e_berr = 0;
        end else begin
            m_ack[0] = 0; m_ack[1] = 0;
            e_en = 0; e_busy = 0; e_done = 0;
            if (m_clearing) begin
                if (m_idx == int'(GC) - 1) begin
                    m_clearing = 0;
                    e_done = 1;
                end else begin
                    m_idx++;
                    e_en = 1; e_addr = AW'(m_idx); e_data = m_col; e_busy = 1;
                end
            end else if (clear_start) begin
                m_clearing = 1; m_idx = 0; m_col = clear_color;
                e_en = 1; e_addr = '0; e_data = m_col; e_busy = 1;
            end else begin
                if (req[0] && !prev_ack[0] && req[1] && !prev_ack[1]) win = 1 - m_last;
                else if (req[0] && !prev_ack[0]) win = 0;
                else if (req[1] && !prev_ack[1]) win = 1;
                if (win >= 0) begin
                    m_ack[win] = 1;
                    m_last = win;
                    if (!BOUNDS || 32'(ad[win]) < GC) begin
                        e_en = 1; e_addr = ad[win]; e_data = dt[win];
                    end else begin
                        e_berr = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom);
        return AW'($urandom_range(0, GC + 4));
    endfunction

    // Safety net: the run has a fixed cycle count, this only guards a stall.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, '0, 0, '0, '0, 0, '0, '0);

        //          name           rst r0 a0      d0    r1 a1      d1    exp {en addr data ack0 ack1 busy done berr}
        tbl[0]  = '{"reset",        1, 0, 12'h000, 4'h0, 0, 12'h000, 4'h0, pk(0, 12'h000, 4'h0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{"p0_single",    0, 1, 12'h0A5, 4'h3, 0, 12'h000, 4'h0, pk(1, 12'h0A5, 4'h3, 1, 0, 0, 0, 0)};
        tbl[2]  = '{"idle_hold",    0, 0, 12'h0A5, 4'h3, 0, 12'h000, 4'h0, pk(0, 12'h0A5, 4'h3, 0, 0, 0, 0, 0)};
        tbl[3]  = '{"reset2",       1, 0, 12'h000, 4'h0, 0, 12'h000, 4'h0, pk(0, 12'h000, 4'h0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{"rr_tie_p0",    0, 1, 12'h010, 4'h1, 1, 12'h020, 4'h2, pk(1, 12'h010, 4'h1, 1, 0, 0, 0, 0)};
        tbl[5]  = '{"rr_p1",        0, 1, 12'h010, 4'h1, 1, 12'h020, 4'h2, pk(1, 12'h020, 4'h2, 0, 1, 0, 0, 0)};
        tbl[6]  = '{"rr_p0_again",  0, 1, 12'h011, 4'h4, 1, 12'h020, 4'h2, pk(1, 12'h011, 4'h4, 1, 0, 0, 0, 0)};
        tbl[7]  = '{"rr_p1_again",  0, 1, 12'h011, 4'h4, 1, 12'h021, 4'h5, pk(1, 12'h021, 4'h5, 0, 1, 0, 0, 0)};
        tbl[8]  = '{"rr_idle",      0, 0, 12'h011, 4'h4, 0, 12'h021, 4'h5, pk(0, 12'h021, 4'h5, 0, 0, 0, 0, 0)};
        tbl[9]  = '{"p1_alone",     0, 0, 12'h000, 4'h0, 1, 12'h030, 4'h6, pk(1, 12'h030, 4'h6, 0, 1, 0, 0, 0)};
        tbl[10] = '{"no_double",    0, 0, 12'h000, 4'h0, 1, 12'h030, 4'h6, pk(0, 12'h030, 4'h6, 0, 0, 0, 0, 0)};
        tbl[11] = '{"drop",         0, 0, 12'h000, 4'h0, 0, 12'h030, 4'h6, pk(0, 12'h030, 4'h6, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, 0, '0, tbl[i].r0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].a1, tbl[i].d1);
            tick();
            check(tbl[i].name, obs(), tbl[i].exp);
        end

        // ---- clear sweep; p0 pending from the start, p1 raised mid-sweep,
        //      a second clear_start mid-sweep; last grant before was p1 ----
        drive(0, 1, 4'h7, 1, 12'h0B0, 4'h1, 0, 12'h000, 4'h0);
        tick();
        check("clr_first", obs(), pk(1, 12'h000, 4'h7, 0, 0, 1, 0, 0));
        clear_start = 0;
        for (int k = 1; k < int'(GC); k++) begin
            if (k == 3) begin p1_req = 1; p1_addr = 12'h055; p1_data = 4'h9; end
            if (k == 8) begin clear_start = 1; clear_color = 4'hA; end
            if (k == 9) clear_start = 0;
            tick();
            check($sformatf("clr_%0d", k), obs(), pk(1, AW'(k), 4'h7, 0, 0, 1, 0, 0));
        end
        tick();
        check("clr_done", obs(), pk(0, 12'h00F, 4'h7, 0, 0, 0, 1, 0));
        tick();
        check("post_clr_p0", obs(), pk(1, 12'h0B0, 4'h1, 1, 0, 0, 0, 0));
        p0_req = 0;
        tick();
        check("post_clr_p1", obs(), pk(1, 12'h055, 4'h9, 0, 1, 0, 0, 0));
        p1_req = 0;
        tick();
        check("post_clr_idle", obs(), pk(0, 12'h055, 4'h9, 0, 0, 0, 0, 0));

        // ---- reset in the middle of a clear ----
        drive(0, 1, 4'h3, 0, '0, '0, 0, '0, '0);
        tick();
        check("clr2_first", obs(), pk(1, 12'h000, 4'h3, 0, 0, 1, 0, 0));
        clear_start = 0;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("clr2_%0d", k), obs(), pk(1, AW'(k), 4'h3, 0, 0, 1, 0, 0));
        end
        reset = 1;
        tick();
        check("mid_clr_reset", obs(), pk(0, 12'h000, 4'h0, 0, 0, 0, 0, 0));
        reset = 0; p0_req = 1; p0_addr = 12'h0C3; p0_data = 4'hE;
        tick();
        check("after_reset_p0", obs(), pk(1, 12'h0C3, 4'hE, 1, 0, 0, 0, 0));
        p0_req = 0;
        tick();
        check("no_resume", obs(), pk(0, 12'h0C3, 4'hE, 0, 0, 0, 0, 0));

        // ---- address bound: 20 is out of range, 15 is the last legal cell ----
        p0_req = 1; p0_addr = 12'd20; p0_data = 4'h5;
        tick();
        check("bound_oor", obs(), BOUNDS ? pk(0, 12'h0C3, 4'hE, 1, 0, 0, 0, 1)
                                         : pk(1, 12'h014, 4'h5, 1, 0, 0, 0, 0));
        p0_req = 0;
        tick();
        check("bound_sticky", obs(), BOUNDS ? pk(0, 12'h0C3, 4'hE, 0, 0, 0, 0, 1)
                                            : pk(0, 12'h014, 4'h5, 0, 0, 0, 0, 0));
        p1_req = 1; p1_addr = 12'd15; p1_data = 4'h2;
        tick();
        check("bound_legal", obs(), pk(1, 12'h00F, 4'h2, 0, 1, 0, 0, BOUNDS));
        p1_req = 0;

        // ---- randomized traffic against the reference model ----
        drive(1, 0, '0, 0, '0, '0, 0, '0, '0);
        model_edge();
        tick();
        check("rand_reset", obs(), pk(e_en, e_addr, e_data, m_ack[0], m_ack[1], e_busy, e_done, e_berr));
        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            clear_start = ($urandom_range(0, 99) < 3);
            clear_color = DW'($urandom);
            if (p0_req && p0_ack) begin
                if ($urandom_range(0, 1) == 0) p0_req = 0;
                else begin p0_addr = rnd_addr(); p0_data = DW'($urandom); end
            end else if (!p0_req && $urandom_range(0, 2) == 0) begin
                p0_req = 1; p0_addr = rnd_addr(); p0_data = DW'($urandom);
            end
            if (p1_req && p1_ack) begin
                if ($urandom_range(0, 1) == 0) p1_req = 0;
                else begin p1_addr = rnd_addr(); p1_data = DW'($urandom); end
            end else if (!p1_req && $urandom_range(0, 2) == 0) begin
                p1_req = 1; p1_addr = rnd_addr(); p1_data = DW'($urandom);
            end
            model_edge();
            tick();
            check("random", obs(), pk(e_en, e_addr, e_data, m_ack[0], m_ack[1], e_busy, e_done, e_berr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
